// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined signed carry-skip adder/subtractor with a global-stall valid/ready pipeline.
// Optional macro CSA_OVF_CNT_EN adds a saturating counter of handshaken overflow results.
module csa_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);
    logic rip;
    logic p;

    always_comb begin
        sum = '0;
        rip = cin;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = a[i] ^ b[i] ^ rip;
            rip    = (a[i] & b[i]) | (rip & (a[i] ^ b[i]));
        end
    end

    assign p    = &(a ^ b);
    assign cout = p ? cin : rip;
endmodule

module csa_slice #(
    parameter int SLICE = 8,
    parameter int BLOCK = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);
    localparam int NG = SLICE / BLOCK;

    for (genvar g = 0; g < NG; g++) begin : grp
        logic ci;
        logic co;
        if (g == 0) begin : g_first
            assign ci = cin;
        end else begin : g_chain
            assign ci = grp[g-1].co;
        end
        csa_group #(.BLOCK(BLOCK)) u_grp (
            .a   (a[g*BLOCK +: BLOCK]),
            .b   (b[g*BLOCK +: BLOCK]),
            .cin (ci),
            .sum (sum[g*BLOCK +: BLOCK]),
            .cout(co)
        );
    end

    assign cout = grp[NG-1].co;
endmodule

module pipelined_carry_skip_adder #(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   sum_o,
    output logic             cout_o,
    output logic             ovf_o
`ifdef CSA_OVF_CNT_EN
    ,
    output logic [15:0]      ovf_cnt_o
`endif
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    typedef struct packed {
        logic [WIDTH:0] sum;
        logic           cout;
        logic           ovf;
    } rsp_t;

    logic              advance;
    logic [WIDTH-1:0]  b_x;
    logic              c0;
    logic [STAGES:1]   vld_pipe;
    rsp_t              rsp_d;
    rsp_t              rsp_q;

    assign advance     = !vld_pipe[STAGES] || out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = vld_pipe[STAGES];

    // Subtraction is A + ~B + ~borrow, so the borrow-in inverts along with B.
    assign b_x = sub_i ? ~b_i : b_i;
    assign c0  = sub_i ? ~cin_i : cin_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid_i;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Block k works on slice k; its inputs are the still-unconsumed upper operand bits.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SLICE;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]       a_in;
        logic [RW-1:0]       b_in;
        logic                c_in;
        logic [SLICE-1:0]    s;
        logic                co;
        logic [LO+SLICE-1:0] sum_acc;

        csa_slice #(.SLICE(SLICE), .BLOCK(BLOCK)) u_slice (
            .a   (a_in[SLICE-1:0]),
            .b   (b_in[SLICE-1:0]),
            .cin (c_in),
            .sum (s),
            .cout(co)
        );

        if (k == 0) begin : g_in
            assign a_in    = a_i;
            assign b_in    = b_x;
            assign c_in    = c0;
            assign sum_acc = s;
        end else begin : g_reg
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic          c_q;
            logic [LO-1:0] ps_q;

            always_ff @(posedge clk_i) begin
                if (advance) begin
                    a_q  <= stg[k-1].a_in[RW+SLICE-1:SLICE];
                    b_q  <= stg[k-1].b_in[RW+SLICE-1:SLICE];
                    c_q  <= stg[k-1].co;
                    ps_q <= stg[k-1].sum_acc;
                end
            end

            assign a_in    = a_q;
            assign b_in    = b_q;
            assign c_in    = c_q;
            assign sum_acc = {s, ps_q};
        end
    end

    // Carry into the MSB is recovered from its sum bit: c = s ^ a ^ b.
    always_comb begin
        rsp_d      = '0;
        rsp_d.cout = stg[LAST].co;
        rsp_d.sum  = {stg[LAST].a_in[SLICE-1] ^ stg[LAST].b_in[SLICE-1] ^ stg[LAST].co,
                      stg[LAST].sum_acc};
        rsp_d.ovf  = stg[LAST].a_in[SLICE-1] ^ stg[LAST].b_in[SLICE-1] ^
                     stg[LAST].s[SLICE-1] ^ stg[LAST].co;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rsp_q <= '0;
        else if (advance) rsp_q <= rsp_d;
    end

    assign sum_o  = rsp_q.sum;
    assign cout_o = rsp_q.cout;
    assign ovf_o  = rsp_q.ovf;

`ifdef CSA_OVF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) ovf_cnt_o <= '0;
        else if (out_valid_o && out_ready_i && ovf_o && ovf_cnt_o != 16'hFFFF)
            ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Scoreboard bench for pipelined_carry_skip_adder (WIDTH=16, BLOCK=4, STAGES=2).
module tb_pipelined_carry_skip_adder;
    logic        clk = 1'b0;
    logic        rst_i, in_valid_i, in_ready_o, cin_i, sub_i;
    logic        out_valid_o, out_ready_i, cout_o, ovf_o;
    logic [15:0] a_i, b_i;
    logic [16:0] sum_o;
`ifdef CSA_OVF_CNT_EN
    logic [15:0] ovf_cnt_o;
`endif

    typedef struct packed {
        logic [16:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t hold, mon_e;
    bit   hold_v = 0;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] va [8] = '{16'h0001, 16'h1234, 16'h0010, 16'h0000, 16'h8000, 16'h7FFF, 16'h00FF, 16'h0005};
    logic [15:0] vb [8] = '{16'h0002, 16'h1111, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'h0F01, 16'h0003};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] es [8] = '{17'h00003, 17'h02345, 17'h0000F, 17'h1FFFF, 17'h10000, 17'h08000, 17'h01001, 17'h00001};
    logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ev [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
        .sub_i      (sub_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .sum_o      (sum_o),
        .cout_o     (cout_o),
        .ovf_o      (ovf_o)
`ifdef CSA_OVF_CNT_EN
        ,
        .ovf_cnt_o  (ovf_cnt_o)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                        input logic [16:0] xs, input logic xc, input logic xv);
        bit ok = 0;
        @(negedge clk);
        a_i = ta; b_i = tb; cin_i = tc; sub_i = ts; in_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (in_ready_o) begin
                ok = 1;
                sb.push_back('{sum: xs, cout: xc, ovf: xv});
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready_o stayed %b, required 1", in_ready_o);
        end
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: compares each handshaken result against the scoreboard head.
    initial forever begin
        @(negedge clk); #1;
        if (rst_i) begin
            hold_v = 0;
        end else begin
            chk("in_ready", in_ready_o, !(out_valid_o && !out_ready_i));
            if (hold_v) begin
                chk("hold_sum", sum_o, hold.sum);
                chk("hold_flags", {cout_o, ovf_o}, {hold.cout, hold.ovf});
            end
            hold_v = out_valid_o && !out_ready_i;
            hold   = '{sum: sum_o, cout: cout_o, ovf: ovf_o};
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got sum %h, required no result", sum_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sum", sum_o, mon_e.sum);
                    chk("cout", cout_o, mon_e.cout);
                    chk("ovf", ovf_o, mon_e.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1; in_valid_i = 0; a_i = 0; b_i = 0; cin_i = 0; sub_i = 0; out_ready_i = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_sum", sum_o, 0);
        chk("rst_flags", {cout_o, ovf_o}, 0);
        chk("rst_ready", in_ready_o, 1);
`ifdef CSA_OVF_CNT_EN
        chk("rst_cnt", ovf_cnt_o, 0);
`endif
        rst_i = 0;

        // Two beats in flight, then a flushing reset.
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid_i = 0; rst_i = 1;
        sb.delete();
        @(negedge clk); #1;
        chk("flush_valid", out_valid_o, 0);
        chk("flush_sum", sum_o, 0);
        chk("flush_ready", in_ready_o, 1);
`ifdef CSA_OVF_CNT_EN
        chk("flush_cnt", ovf_cnt_o, 0);
`endif
        rst_i = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("flush_quiet", out_valid_o, 0);

        // Directed cases with latency check on the first.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid_i = 0; #1;
        chk("lat_early", out_valid_o, 0);
        @(negedge clk); #1;
        chk("lat_exact", out_valid_o, 1);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17'h1FFFE, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 1'b1);
        send(16'h5555, 16'hAAAA, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0);
        @(negedge clk);
        in_valid_i = 0;
        drain();
        repeat (2) @(negedge clk);
        #1;
`ifdef CSA_OVF_CNT_EN
        chk("cnt_after_directed", ovf_cnt_o, 2);
`endif

        // Back-to-back stream with a consumer stall.
        fork
            begin
                for (int i = 0; i < 8; i++) send(va[i], vb[i], vc[i], vs[i], es[i], ec[i], ev[i]);
                @(negedge clk);
                in_valid_i = 0;
            end
            begin
                repeat (5) @(negedge clk);
                out_ready_i = 0;
                repeat (3) @(negedge clk);
                out_ready_i = 1;
            end
        join
        drain();
        repeat (2) @(negedge clk);
        #1;
        chk("stream_empty", sb.size(), 0);
`ifdef CSA_OVF_CNT_EN
        chk("cnt_after_stream", ovf_cnt_o, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
